// File: rtl/biquad_iir_mc.sv
// biquad_iir_mc
//   Time-multiplexed, multi-channel Direct-Form-I biquad IIR section.
//   A single shared multiplier evaluates the five taps of one channel's
//   sample over five MAC cycles. Each accepted sample occupies 7 clocks.
//   Per-channel x/y history is kept internally. Coefficients are written to
//   a shadow bank and copied to the active bank only between samples.
//   The default coefficients implement the 1 Hz Butterworth highpass.
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   enable       0: synchronous clear of FSM, history and pending commit
//   in_valid     sample offered
//   in_ready     block can accept a sample this cycle
//   in_chan      channel of the offered sample
//   in_data      signed input sample (DW bits)
//   out_valid    one-cycle pulse, result valid
//   out_chan     channel of the result
//   out_data     signed filtered sample (DW bits)
//   out_sat      result was clipped (qualified by out_valid)
//   err_chan     one-cycle pulse: accepted in_chan >= NCH
//   coef_we      write coef_wdata into shadow coef[coef_addr]
//   coef_addr    0=b0 1=b1 2=b2 3=a1 4=a2, 5..7 ignored
//   coef_wdata   signed coefficient, FRAC fraction bits
//   coef_commit  request shadow->active copy at the next sample boundary
module biquad_iir_mc #(
  parameter int DW   = 32,
  parameter int CW   = 16,
  parameter int FRAC = 13,
  parameter int NCH  = 8,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CHW-1:0]        in_chan,
  input  logic signed [DW-1:0]  in_data,
  output logic                  out_valid,
  output logic [CHW-1:0]        out_chan,
  output logic signed [DW-1:0]  out_data,
  output logic                  out_sat,
  output logic                  err_chan,
  input  logic                  coef_we,
  input  logic [2:0]            coef_addr,
  input  logic signed [CW-1:0]  coef_wdata,
  input  logic                  coef_commit
);

  localparam int PW = DW + CW;
  localparam int AW = DW + CW + 3;
  localparam logic signed [AW-1:0] HALF = {{(AW-1){1'b0}}, 1'b1} << (FRAC - 1);

  localparam logic signed [CW-1:0] B0_DEF = CW'(8192);
  localparam logic signed [CW-1:0] B1_DEF = CW'(-16384);
  localparam logic signed [CW-1:0] B2_DEF = CW'(8192);
  localparam logic signed [CW-1:0] A1_DEF = CW'(-16100);
  localparam logic signed [CW-1:0] A2_DEF = CW'(7913);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_WB
  } state_t;

  state_t                 state;
  logic [2:0]             k;
  logic signed [AW-1:0]   acc;
  logic [CHW-1:0]         cur_ch;
  logic signed [DW-1:0]   cur_x;
  logic                   commit_pend;

  logic signed [CW-1:0]   shd     [5];
  logic signed [CW-1:0]   shd_nxt [5];
  logic signed [CW-1:0]   act     [5];

  logic signed [DW-1:0]   hx1 [NCH];
  logic signed [DW-1:0]   hx2 [NCH];
  logic signed [DW-1:0]   hy1 [NCH];
  logic signed [DW-1:0]   hy2 [NCH];

  logic signed [CW-1:0]   mul_c;
  logic signed [DW-1:0]   mul_d;
  logic signed [PW-1:0]   mc_ext;
  logic signed [PW-1:0]   md_ext;
  logic signed [PW-1:0]   prod;

  logic signed [AW-1:0]   rsum;
  logic signed [AW-1:0]   rsh;
  logic                   pos_ovf;
  logic                   neg_ovf;
  logic signed [DW-1:0]   ydat;
  logic                   chan_bad;

  assign in_ready = rst_n & enable & (state == S_IDLE) & ~commit_pend;
  assign chan_bad = (int'(in_chan) >= NCH);

  // Shadow bank next value; a commit copies this so a write in the same
  // cycle as the copy is not lost.
  always_comb begin
    for (int unsigned i = 0; i < 5; i++) begin
      shd_nxt[i] = shd[i];
    end
    if (coef_we && (coef_addr < 3'd5)) begin
      shd_nxt[coef_addr] = coef_wdata;
    end
  end

  // Tap select for the shared multiplier: b0*x, b1*x1, b2*x2, a1*y1, a2*y2.
  always_comb begin
    mul_c = '0;
    mul_d = '0;
    case (k)
      3'd0: begin mul_c = act[0]; mul_d = cur_x;        end
      3'd1: begin mul_c = act[1]; mul_d = hx1[cur_ch];  end
      3'd2: begin mul_c = act[2]; mul_d = hx2[cur_ch];  end
      3'd3: begin mul_c = act[3]; mul_d = hy1[cur_ch];  end
      3'd4: begin mul_c = act[4]; mul_d = hy2[cur_ch];  end
      default: ;
    endcase
  end

  assign mc_ext = PW'(mul_c);
  assign md_ext = PW'(mul_d);
  assign prod   = mc_ext * md_ext;

  // Round half up, arithmetic shift, then clip to the DW-bit range.
  assign rsum    = acc + HALF;
  assign rsh     = rsum >>> FRAC;
  assign pos_ovf = ~rsh[AW-1] & (|rsh[AW-2:DW-1]);
  assign neg_ovf = rsh[AW-1] & ~(&rsh[AW-2:DW-1]);

  always_comb begin
    ydat = rsh[DW-1:0];
    if (pos_ovf) begin
      ydat = {1'b0, {(DW-1){1'b1}}};
    end else if (neg_ovf) begin
      ydat = {1'b1, {(DW-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      k           <= '0;
      acc         <= '0;
      cur_ch      <= '0;
      cur_x       <= '0;
      commit_pend <= 1'b0;
      out_valid   <= 1'b0;
      out_chan    <= '0;
      out_data    <= '0;
      out_sat     <= 1'b0;
      err_chan    <= 1'b0;
      shd[0] <= B0_DEF; shd[1] <= B1_DEF; shd[2] <= B2_DEF;
      shd[3] <= A1_DEF; shd[4] <= A2_DEF;
      act[0] <= B0_DEF; act[1] <= B1_DEF; act[2] <= B2_DEF;
      act[3] <= A1_DEF; act[4] <= A2_DEF;
      for (int unsigned i = 0; i < NCH; i++) begin
        hx1[i] <= '0;
        hx2[i] <= '0;
        hy1[i] <= '0;
        hy2[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 5; i++) begin
        shd[i] <= shd_nxt[i];
      end
      out_valid <= 1'b0;
      err_chan  <= 1'b0;

      if (!enable) begin
        state       <= S_IDLE;
        k           <= '0;
        acc         <= '0;
        commit_pend <= 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
          hx1[i] <= '0;
          hx2[i] <= '0;
          hy1[i] <= '0;
          hy2[i] <= '0;
        end
      end else begin
        if (coef_commit) begin
          commit_pend <= 1'b1;
        end

        case (state)
          S_IDLE: begin
            if (commit_pend) begin
              // Copy takes the whole IDLE cycle so no sample sees a mixed bank.
              for (int unsigned i = 0; i < 5; i++) begin
                act[i] <= shd_nxt[i];
              end
              commit_pend <= 1'b0;
            end else if (in_valid) begin
              if (chan_bad) begin
                err_chan <= 1'b1;
              end else begin
                cur_ch <= in_chan;
                cur_x  <= in_data;
                k      <= '0;
                acc    <= '0;
                state  <= S_MAC;
              end
            end
          end

          S_MAC: begin
            if (k < 3'd3) begin
              acc <= acc + AW'(prod);
            end else begin
              acc <= acc - AW'(prod);
            end
            k <= k + 3'd1;
            if (k == 3'd4) begin
              state <= S_WB;
            end
          end

          S_WB: begin
            out_data  <= ydat;
            out_chan  <= cur_ch;
            out_sat   <= pos_ovf | neg_ovf;
            out_valid <= 1'b1;
            hx2[cur_ch] <= hx1[cur_ch];
            hx1[cur_ch] <= cur_x;
            hy2[cur_ch] <= hy1[cur_ch];
            hy1[cur_ch] <= ydat;
            state <= S_IDLE;
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
